// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA HS/VS receiver: position recovery, geometry check, lock tracking
module vga_sync_decoder #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 521,
  parameter int H_DISP_START = 144,
  parameter int H_DISP_END   = 784,
  parameter int V_DISP_START = 31,
  parameter int V_DISP_END   = 511,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       HS,
  input  logic       VS,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       in_display,
  output logic       locked,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam logic [9:0] LP_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] LP_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] LP_H_DS   = 10'(H_DISP_START);
  localparam logic [9:0] LP_H_DE   = 10'(H_DISP_END);
  localparam logic [9:0] LP_V_DS   = 10'(V_DISP_START);
  localparam logic [9:0] LP_V_DE   = 10'(V_DISP_END);
  localparam logic [9:0] LP_CNT_MAX = 10'h3FF;
  localparam logic [7:0] LP_LOCK_N  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Synchronizer and sampled-sync registers (idle level of the syncs is 1)
  logic r_hs_s1, r_hs_s2, r_vs_s1, r_vs_s2;
  logic r_hs_q, r_vs_q;

  logic [9:0] r_col, r_row;
  state_t     r_state;
  logic [7:0] r_good_frames;
  logic       r_locked;
  logic       r_in_display;
  logic       r_frame_err;
  logic [7:0] r_err_count;

  logic       w_hs_fall, w_vs_fall;
  logic [9:0] w_col_nxt, w_row_nxt;
  logic       w_line_err, w_vert_err, w_geom_err;
  state_t     w_state_nxt;
  logic [7:0] w_good_nxt;
  logic       w_err_pulse;
  logic       w_window;

  // Two-flop synchronizers run every clk regardless of pix_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs_s1 <= 1'b1;
      r_hs_s2 <= 1'b1;
      r_vs_s1 <= 1'b1;
      r_vs_s2 <= 1'b1;
    end else begin
      r_hs_s1 <= HS;
      r_hs_s2 <= r_hs_s1;
      r_vs_s1 <= VS;
      r_vs_s2 <= r_vs_s1;
    end
  end

  // Previous-pixel sync levels, captured once per pixel period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs_q <= 1'b1;
      r_vs_q <= 1'b1;
    end else if (pix_en) begin
      r_hs_q <= r_hs_s2;
      r_vs_q <= r_vs_s2;
    end
  end

  assign w_hs_fall = pix_en & ~r_hs_s2 & r_hs_q;
  assign w_vs_fall = pix_en & ~r_vs_s2 & r_vs_q;

  // Next counter values; a VS edge wins over the HS row increment
  always_comb begin
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (w_hs_fall) begin
      w_col_nxt = 10'd0;
      w_row_nxt = (r_row == LP_CNT_MAX) ? r_row : r_row + 10'd1;
    end else begin
      w_col_nxt = (r_col == LP_CNT_MAX) ? r_col : r_col + 10'd1;
    end
    if (w_vs_fall) begin
      w_row_nxt = 10'd0;
    end
  end

  // Geometry violations; "reaches total" fires on the step that would land on the total
  always_comb begin
    w_line_err = 1'b0;
    w_vert_err = 1'b0;
    if (w_hs_fall) begin
      w_line_err = (r_col != LP_H_LAST);
    end else if (pix_en) begin
      w_line_err = (r_col == LP_H_LAST);
    end
    if (w_vs_fall) begin
      w_vert_err = (r_row != LP_V_LAST);
    end else if (w_hs_fall) begin
      w_vert_err = (r_row == LP_V_LAST);
    end
    w_geom_err = w_line_err | w_vert_err;
  end

  // Lock FSM next-state logic; only one error pulse per pixel even if both checks fail
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_frames;
    w_err_pulse = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_vs_fall) begin
          w_state_nxt = ST_ACQUIRE;
          w_good_nxt  = 8'd0;
        end
      end
      ST_ACQUIRE: begin
        if (w_geom_err) begin
          w_state_nxt = ST_SEARCH;
          w_err_pulse = 1'b1;
        end else if (w_vs_fall) begin
          w_good_nxt = r_good_frames + 8'd1;
          if ((r_good_frames + 8'd1) >= LP_LOCK_N) begin
            w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (w_geom_err) begin
          w_state_nxt = ST_SEARCH;
          w_err_pulse = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase
  end

  assign w_window = (w_col_nxt >= LP_H_DS) && (w_col_nxt < LP_H_DE) &&
                    (w_row_nxt >= LP_V_DS) && (w_row_nxt < LP_V_DE);

  // Position counters advance once per pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= 10'd0;
      r_row <= 10'd0;
    end else if (pix_en) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // FSM state and good-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_SEARCH;
      r_good_frames <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_good_frames <= w_good_nxt;
    end
  end

  // Registered status: locked and the error pulse change on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_frame_err <= w_err_pulse;
    end
  end

  // Visible-window flag built from the updated counters so it aligns with col/row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_display <= 1'b0;
    end else if (pix_en) begin
      r_in_display <= (w_state_nxt == ST_LOCKED) && w_window;
    end
  end

  // Saturating error counter, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if (w_err_pulse && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign col        = r_col;
  assign row        = r_row;
  assign in_display = r_in_display;
  assign locked     = r_locked;
  assign frame_err  = r_frame_err;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder on a scaled-down raster
module tb_vga_sync_decoder;

  localparam int HT  = 20;
  localparam int VT  = 12;
  localparam int HDS = 5;
  localparam int HDE = 17;
  localparam int VDS = 2;
  localparam int VDE = 10;
  localparam int HS_LEN = 3;
  localparam int VS_LINES = 2;
  localparam int RUN_LIMIT = HT * VT + HT + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;
  logic       HS;
  logic       VS;
  logic [9:0] col;
  logic [9:0] row;
  logic       in_display;
  logic       locked;
  logic       frame_err;
  logic [7:0] err_count;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT),
    .H_DISP_START(HDS), .H_DISP_END(HDE),
    .V_DISP_START(VDS), .V_DISP_END(VDE),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .HS(HS), .VS(VS),
    .col(col), .row(row), .in_display(in_display), .locked(locked),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   r;
    int   c;
    logic exp_disp;
  } win_vec_t;

  win_vec_t tbl[11];

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int src_col, src_row, last_c, last_r;
  int short_row = -1;
  bit suppress_vs = 1'b0;
  int p0;

  always @(posedge clk) begin
    if (frame_err === 1'b1) n_pulses <= n_pulses + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One pixel period: syncs change, pix_en strobes on the 4th clk, returns on a negedge
  task automatic pix_step(input logic hs, input logic vs);
    HS = hs;
    VS = vs;
    pix_en = 1'b0;
    repeat (3) @(negedge clk);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic gen_pixel();
    logic hs, vs;
    int   line_len;
    hs = !(src_col < HS_LEN);
    vs = suppress_vs ? 1'b1 : !(src_row < VS_LINES);
    pix_step(hs, vs);
    last_c = src_col;
    last_r = src_row;
    line_len = (src_row == short_row) ? HT - 1 : HT;
    src_col++;
    if (src_col >= line_len) begin
      src_col = 0;
      src_row = (src_row + 1) % VT;
    end
  endtask

  task automatic run_to(input int r, input int c);
    int n;
    n = 0;
    do begin
      gen_pixel();
      n++;
    end while (!(last_r == r && last_c == c) && n < RUN_LIMIT);
    if (!(last_r == r && last_c == c)) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_to(%0d,%0d): stopped at %0d,%0d", r, c, last_r, last_c);
    end
  endtask

  task automatic storm_iter();
    pix_step(1'b1, 1'b0);
    pix_step(1'b1, 1'b1);
    pix_step(1'b0, 1'b0);
    pix_step(1'b1, 1'b1);
  endtask

  initial begin
    tbl[0]  = '{r: 1,  c: 10, exp_disp: 1'b0};
    tbl[1]  = '{r: 2,  c: 4,  exp_disp: 1'b0};
    tbl[2]  = '{r: 2,  c: 5,  exp_disp: 1'b1};
    tbl[3]  = '{r: 2,  c: 16, exp_disp: 1'b1};
    tbl[4]  = '{r: 2,  c: 17, exp_disp: 1'b0};
    tbl[5]  = '{r: 5,  c: 0,  exp_disp: 1'b0};
    tbl[6]  = '{r: 6,  c: 8,  exp_disp: 1'b1};
    tbl[7]  = '{r: 9,  c: 5,  exp_disp: 1'b1};
    tbl[8]  = '{r: 9,  c: 16, exp_disp: 1'b1};
    tbl[9]  = '{r: 10, c: 10, exp_disp: 1'b0};
    tbl[10] = '{r: 11, c: 19, exp_disp: 1'b0};

    rst = 1'b1;
    pix_en = 1'b0;
    HS = 1'b1;
    VS = 1'b1;
    repeat (3) @(negedge clk);
    check("reset col", 32'(col), 0);
    check("reset row", 32'(row), 0);
    check("reset in_display", 32'(in_display), 0);
    check("reset locked", 32'(locked), 0);
    check("reset frame_err", 32'(frame_err), 0);
    check("reset err_count", 32'(err_count), 0);
    rst = 1'b0;

    // Nominal stream: lock on the 2nd VS edge after the first
    src_row = 11;
    src_col = 15;
    run_to(0, 0);
    check("edge1 col", 32'(col), 0);
    check("edge1 row", 32'(row), 0);
    check("edge1 locked", 32'(locked), 0);
    run_to(0, 0);
    check("edge2 locked", 32'(locked), 0);
    run_to(0, 0);
    check("edge3 col", 32'(col), 0);
    check("edge3 row", 32'(row), 0);
    check("edge3 locked", 32'(locked), 1);

    // Visible window while locked
    for (int i = 0; i < 11; i++) begin
      run_to(tbl[i].r, tbl[i].c);
      check($sformatf("win col r%0d c%0d", tbl[i].r, tbl[i].c), 32'(col), 32'(tbl[i].c));
      check($sformatf("win row r%0d c%0d", tbl[i].r, tbl[i].c), 32'(row), 32'(tbl[i].r));
      check($sformatf("win disp r%0d c%0d", tbl[i].r, tbl[i].c), 32'(in_display), 32'(tbl[i].exp_disp));
    end
    run_to(0, 0);
    repeat (2) @(negedge clk);
    check("nominal locked", 32'(locked), 1);
    check("nominal pulses", 32'(n_pulses), 0);
    check("nominal err_count", 32'(err_count), 0);

    // Short line: HS edge one pixel early
    short_row = 3;
    run_to(4, 0);
    check("short frame_err", 32'(frame_err), 1);
    check("short locked", 32'(locked), 0);
    check("short err_count", 32'(err_count), 1);
    check("short in_display", 32'(in_display), 0);
    @(negedge clk);
    check("short pulse width", 32'(frame_err), 0);
    short_row = -1;
    run_to(0, 0);
    check("short relock acq", 32'(locked), 0);
    run_to(0, 0);
    check("short relock good1", 32'(locked), 0);
    run_to(0, 0);
    check("short relock good2", 32'(locked), 1);
    check("short err_count hold", 32'(err_count), 1);

    // Missing VS: row runs past V_TOTAL-1
    suppress_vs = 1'b1;
    run_to(0, 0);
    check("novs frame_err", 32'(frame_err), 1);
    check("novs locked", 32'(locked), 0);
    check("novs row", 32'(row), 12);
    check("novs err_count", 32'(err_count), 2);
    run_to(1, HT - 1);
    suppress_vs = 1'b0;
    run_to(0, 0);
    check("novs relock acq", 32'(locked), 0);
    run_to(0, 0);
    check("novs relock good1", 32'(locked), 0);
    run_to(0, 0);
    check("novs relock good2", 32'(locked), 1);
    check("novs err_count hold", 32'(err_count), 2);

    // Reset mid-frame while locked
    run_to(5, 7);
    #2 rst = 1'b1;
    #1;
    check("midrst col", 32'(col), 0);
    check("midrst row", 32'(row), 0);
    check("midrst in_display", 32'(in_display), 0);
    check("midrst locked", 32'(locked), 0);
    check("midrst frame_err", 32'(frame_err), 0);
    check("midrst err_count", 32'(err_count), 0);
    @(negedge clk);
    rst = 1'b0;
    p0 = n_pulses;
    run_to(0, 0);
    run_to(0, 0);
    check("midrst good1 locked", 32'(locked), 0);
    run_to(0, 0);
    check("midrst relock", 32'(locked), 1);
    repeat (2) @(negedge clk);
    check("midrst no pulse", 32'(n_pulses - p0), 0);
    check("midrst err_count", 32'(err_count), 0);

    // Stall: pix_en low for 1000 clks while syncs toggle
    run_to(3, 6);
    check("stall pre col", 32'(col), 6);
    check("stall pre row", 32'(row), 3);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      HS = ~HS;
      VS = ~VS;
    end
    HS = 1'b1;
    VS = 1'b1;
    check("stall col", 32'(col), 6);
    check("stall row", 32'(row), 3);
    check("stall locked", 32'(locked), 1);
    run_to(0, 0);
    check("stall resume locked", 32'(locked), 1);
    check("stall resume err_count", 32'(err_count), 0);

    // Error storm: each iteration yields exactly one error (HS and VS fail together)
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    p0 = n_pulses;
    for (int i = 0; i < 10; i++) storm_iter();
    repeat (2) @(negedge clk);
    check("storm10 err_count", 32'(err_count), 10);
    check("storm10 pulses", 32'(n_pulses - p0), 10);
    for (int i = 0; i < 290; i++) storm_iter();
    check("storm sat err_count", 32'(err_count), 255);

    // Column saturation with no HS edges
    for (int i = 0; i < 1030; i++) pix_step(1'b1, 1'b1);
    check("col saturate", 32'(col), 1023);
    check("col saturate err_count", 32'(err_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
